// File: rtl/bram_tile_manager.sv
// Tile-level front end to the attention-matrix BRAM store: moves one TILE_DIM x TILE_DIM tile per request, one row per cycle.
// Optional transposed reads are enabled by defining BRAM_TILE_TRANSPOSE_EN.
module bram_tile_manager #(
  parameter int DATA_W   = 8,
  parameter int TILE_DIM = 16,
  parameter int MAT_NUM  = 4,
  parameter int MAT_W    = 2,
  parameter int LINE_W   = 6,
  parameter int COL_W    = 3
) (
  input  logic                                I_CLK,
  input  logic                                I_RST,
  input  logic                                I_RD_ENA,
  input  logic                                I_WR_ENA,
  input  logic [MAT_W-1:0]                    I_SEL_MAT,
  input  logic [LINE_W-1:0]                   I_SEL_LINE,
  input  logic [COL_W-1:0]                    I_SEL_COL,
  input  logic [TILE_DIM*TILE_DIM*DATA_W-1:0] I_MAT,
`ifdef BRAM_TILE_TRANSPOSE_EN
  input  logic                                I_TRANSPOSE,
`endif
  output logic                                O_BUSY,
  output logic                                O_VLD,
  output logic [TILE_DIM*TILE_DIM*DATA_W-1:0] O_MAT,
  output logic                                O_WR_DONE,
  output logic                                O_ERR
);

  localparam int ROW_W  = TILE_DIM * DATA_W;
  localparam int TILE_W = ROW_W * TILE_DIM;
  localparam int CNT_W  = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
  localparam int ADDR_W = MAT_W + LINE_W + COL_W + CNT_W;
  localparam int DEPTH  = MAT_NUM << (LINE_W + COL_W + CNT_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TILE_DIM - 1);

  typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, HOLD} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [MAT_W-1:0]    lat_mat;
  logic [LINE_W-1:0]   lat_line;
  logic [COL_W-1:0]    lat_col;
  logic                lat_tr;
  logic [TILE_W-1:0]   snap;
  logic [ROW_W-1:0]    snap_row;
  logic [ROW_W-1:0]    rdata_p1;
  logic [ROW_W-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we, mem_re;
  logic                accept, err_nx, vld_nx, done_nx, cap_en;
  logic [CNT_W-1:0]    cap_row;
  logic [31:0]         sel_ext;

  // Drops one returned row into the output tile, either as row r or scattered into column r.
  function automatic logic [TILE_W-1:0] place_row(input logic [TILE_W-1:0] cur,
                                                  input logic [ROW_W-1:0]  word,
                                                  input logic [CNT_W-1:0]  r,
                                                  input logic              tr);
    logic [TILE_W-1:0] t;
    t = cur;
    if (tr) begin
      for (int i = 0; i < TILE_DIM; i++)
        t[(i*TILE_DIM + int'(r))*DATA_W +: DATA_W] = word[i*DATA_W +: DATA_W];
    end else begin
      t[int'(r)*ROW_W +: ROW_W] = word;
    end
    return t;
  endfunction

  assign sel_ext  = 32'(I_SEL_MAT);
  assign mem_addr = {lat_mat, lat_line, lat_col, cnt};
  assign snap_row = snap[ROW_W*int'(cnt) +: ROW_W];
  assign O_BUSY   = (state == RD) || (state == RD_LAST) || (state == WR);

`ifdef BRAM_TILE_TRANSPOSE_EN
  always_ff @(posedge I_CLK) begin
    if (accept) lat_tr <= I_TRANSPOSE;
  end
`else
  assign lat_tr = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    err_nx   = 1'b0;
    vld_nx   = 1'b0;
    done_nx  = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    cap_en   = 1'b0;
    cap_row  = cnt - 1'b1;
    case (state)
      IDLE: begin
        if (I_WR_ENA || I_RD_ENA) begin
          accept = 1'b1;
          cnt_nx = '0;
          if (sel_ext >= 32'(MAT_NUM)) begin
            err_nx   = 1'b1;
            state_nx = HOLD;
          end else if (I_WR_ENA) begin
            state_nx = WR;
          end else begin
            state_nx = RD;
          end
        end
      end
      WR: begin
        mem_we = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST) begin
          done_nx  = 1'b1;
          state_nx = HOLD;
        end
      end
      RD: begin
        // Row cnt-1 arrives from the RAM while row cnt is being requested.
        mem_re = 1'b1;
        cnt_nx = cnt + 1'b1;
        cap_en = (cnt != '0);
        if (cnt == LAST) state_nx = RD_LAST;
      end
      RD_LAST: begin
        cap_en   = 1'b1;
        cap_row  = LAST;
        vld_nx   = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (!I_WR_ENA && !I_RD_ENA) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state     <= IDLE;
      cnt       <= '0;
      O_VLD     <= 1'b0;
      O_WR_DONE <= 1'b0;
      O_ERR     <= 1'b0;
      O_MAT     <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      O_VLD     <= vld_nx;
      O_WR_DONE <= done_nx;
      O_ERR     <= err_nx;
      if (cap_en) O_MAT <= place_row(O_MAT, rdata_p1, cap_row, lat_tr);
    end
  end

  always_ff @(posedge I_CLK) begin
    if (accept) begin
      lat_mat  <= I_SEL_MAT;
      lat_line <= I_SEL_LINE;
      lat_col  <= I_SEL_COL;
    end
    if (accept && I_WR_ENA) snap <= I_MAT;
  end

  // Store stage: registered read data becomes rdata_p1.
  always_ff @(posedge I_CLK) begin
    if (mem_we) mem[mem_addr] <= snap_row;
    if (mem_re) rdata_p1 <= mem[mem_addr];
  end

endmodule

// File: tb/tb_bram_tile_manager.sv
// Directed and randomized checks of bram_tile_manager against a tile-level reference store.
module tb_bram_tile_manager;
  localparam int DATA_W   = 8;
  localparam int TILE_DIM = 16;
  localparam int LINE_W   = 6;
  localparam int COL_W    = 3;
  localparam int ROW_W    = TILE_DIM * DATA_W;
  localparam int TILE_W   = ROW_W * TILE_DIM;

  logic              clk = 1'b0;
  logic              rst, rd, wr, tr;
  logic [1:0]        sel_mat;
  logic [LINE_W-1:0] sel_line;
  logic [COL_W-1:0]  sel_col;
  logic [TILE_W-1:0] imat;
  logic              busy, vld, done, err;
  logic [TILE_W-1:0] omat;
  logic              e_busy, e_vld, e_done, e_err;
  logic [TILE_W-1:0] e_omat;

  int n_cmp = 0;
  int n_bad = 0;
  logic [TILE_W-1:0] model [int];
  int keys [$];

  always #5 clk = ~clk;

  bram_tile_manager #(.DATA_W(DATA_W), .TILE_DIM(TILE_DIM), .MAT_NUM(4), .MAT_W(2),
                      .LINE_W(LINE_W), .COL_W(COL_W)) dut (
    .I_CLK(clk), .I_RST(rst), .I_RD_ENA(rd), .I_WR_ENA(wr),
    .I_SEL_MAT(sel_mat), .I_SEL_LINE(sel_line), .I_SEL_COL(sel_col), .I_MAT(imat),
`ifdef BRAM_TILE_TRANSPOSE_EN
    .I_TRANSPOSE(tr),
`endif
    .O_BUSY(busy), .O_VLD(vld), .O_MAT(omat), .O_WR_DONE(done), .O_ERR(err));

  // Same stimulus, but with only three matrices so that select 3 is out of range.
  bram_tile_manager #(.DATA_W(DATA_W), .TILE_DIM(TILE_DIM), .MAT_NUM(3), .MAT_W(2),
                      .LINE_W(LINE_W), .COL_W(COL_W)) dut_e (
    .I_CLK(clk), .I_RST(rst), .I_RD_ENA(rd), .I_WR_ENA(wr),
    .I_SEL_MAT(sel_mat), .I_SEL_LINE(sel_line), .I_SEL_COL(sel_col), .I_MAT(imat),
`ifdef BRAM_TILE_TRANSPOSE_EN
    .I_TRANSPOSE(tr),
`endif
    .O_BUSY(e_busy), .O_VLD(e_vld), .O_MAT(e_omat), .O_WR_DONE(e_done), .O_ERR(e_err));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tile(input string tag, input logic [TILE_W-1:0] obs, input logic [TILE_W-1:0] exp);
    int br;
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      br = 0;
      for (int r = TILE_DIM-1; r >= 0; r--)
        if (obs[r*ROW_W +: ROW_W] !== exp[r*ROW_W +: ROW_W]) br = r;
      $error("FAIL %s: row %0d observed %h expected %h", tag, br,
             obs[br*ROW_W +: ROW_W], exp[br*ROW_W +: ROW_W]);
    end
  endtask

  function automatic int key(input int m, input int l, input int c);
    return (m << 16) | (l << 8) | c;
  endfunction

  function automatic logic [TILE_W-1:0] fill(input logic [7:0] v);
    logic [TILE_W-1:0] t;
    for (int i = 0; i < TILE_DIM*TILE_DIM; i++) t[i*DATA_W +: DATA_W] = v;
    return t;
  endfunction

  function automatic logic [TILE_W-1:0] rand_tile();
    logic [TILE_W-1:0] t;
    for (int i = 0; i < TILE_W/32; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  function automatic logic [TILE_W-1:0] transpose_t(input logic [TILE_W-1:0] t);
    logic [TILE_W-1:0] o;
    for (int i = 0; i < TILE_DIM; i++)
      for (int j = 0; j < TILE_DIM; j++)
        o[(i*TILE_DIM+j)*DATA_W +: DATA_W] = t[(j*TILE_DIM+i)*DATA_W +: DATA_W];
    return o;
  endfunction

  task automatic scramble_sel();
    sel_mat  = 2'($urandom_range(0, 3));
    sel_line = LINE_W'($urandom);
    sel_col  = COL_W'($urandom);
  endtask

  task automatic model_put(input int k, input logic [TILE_W-1:0] t);
    if (!model.exists(k)) keys.push_back(k);
    model[k] = t;
  endtask

  // Full write transaction; acceptance edge is the first tick.
  task automatic do_write(input int m, input int l, input int c, input logic [TILE_W-1:0] t);
    int lat;
    sel_mat = 2'(m); sel_line = LINE_W'(l); sel_col = COL_W'(c); imat = t;
    wr = 1'b1;
    tick();
    chk("wr_busy", busy, 1);
    wr = 1'b0;
    imat = rand_tile();
    scramble_sel();
    lat = 0;
    for (int k = 1; k <= TILE_DIM + 8 && lat == 0; k++) begin
      tick();
      if (done) lat = k;
    end
    chk("wr_latency", lat, TILE_DIM);
    chk("wr_busy_hold", busy, 0);
    tick();
    chk("wr_done_pulse", done, 0);
    model_put(key(m, l, c), t);
  endtask

  task automatic do_read(input int m, input int l, input int c, output logic [TILE_W-1:0] t);
    int lat;
    sel_mat = 2'(m); sel_line = LINE_W'(l); sel_col = COL_W'(c);
    rd = 1'b1;
    tick();
    chk("rd_busy", busy, 1);
    rd = 1'b0;
    scramble_sel();
    lat = 0;
    t = '0;
    for (int k = 1; k <= TILE_DIM + 8 && lat == 0; k++) begin
      tick();
      if (vld) begin
        lat = k;
        t = omat;
      end
    end
    chk("rd_latency", lat, TILE_DIM + 1);
    chk("rd_busy_hold", busy, 0);
    tick();
    chk("rd_vld_pulse", vld, 0);
  endtask

  initial begin
    logic [TILE_W-1:0] t, exp_t, a_t, b_t;
    int nv, nd, ne, first, lat, k, m, l, c;

    rst = 1'b1; rd = 1'b0; wr = 1'b0; tr = 1'b0;
    sel_mat = '0; sel_line = '0; sel_col = '0; imat = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_vld", vld, 0);
    chk("rst_wr_done", done, 0);
    chk("rst_err", err, 0);
    chk_tile("rst_mat", omat, '0);
    rst = 1'b0;
    tick();

    // Row pattern 55/66/77/88 repeating, write then read back.
    for (int r = 0; r < TILE_DIM; r++)
      for (int cc = 0; cc < TILE_DIM; cc++)
        exp_t[(r*TILE_DIM+cc)*DATA_W +: DATA_W] = 8'h55 + 8'h11 * 8'(r % 4);
    do_write(3, 1, 0, exp_t);
    do_read(3, 1, 0, t);
    chk_tile("pattern_rows", t, exp_t);

    // Distinct matrices at the same line/col must not alias.
    do_write(0, 1, 0, fill(8'h11));
    do_write(1, 1, 0, fill(8'h22));
    do_write(2, 1, 0, fill(8'h33));
    do_read(0, 1, 0, t); chk_tile("alias_mat0", t, fill(8'h11));
    do_read(1, 1, 0, t); chk_tile("alias_mat1", t, fill(8'h22));
    do_read(2, 1, 0, t); chk_tile("alias_mat2", t, fill(8'h33));

    // Simultaneous read and write: the write wins, the read is dropped.
    sel_mat = 2'd0; sel_line = 6'd2; sel_col = 3'd0; imat = fill(8'hA5);
    wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    nv = 0; nd = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (vld) nv++;
      if (done) nd++;
    end
    chk("both_vld_count", nv, 0);
    chk("both_done_count", nd, 1);
    model_put(key(0, 2, 0), fill(8'hA5));
    do_read(0, 2, 0, t);
    chk_tile("both_readback", t, fill(8'hA5));

    // Read enable held high: one tile only, then a re-raise retriggers.
    sel_mat = 2'd3; sel_line = 6'd1; sel_col = 3'd0;
    rd = 1'b1;
    tick();
    nv = 0; first = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (vld) begin
        nv++;
        if (first == 0) first = i;
      end
    end
    chk("hold_vld_count", nv, 1);
    chk("hold_vld_first", first, TILE_DIM + 1);
    rd = 1'b0;
    tick();
    rd = 1'b1;
    tick();
    lat = 0;
    for (int i = 1; i <= TILE_DIM + 8 && lat == 0; i++) begin
      tick();
      if (vld) lat = i;
    end
    chk("rearm_latency", lat, TILE_DIM + 1);
    chk_tile("rearm_tile", omat, model[key(3, 1, 0)]);
    rd = 1'b0;
    tick(); tick();

    // Out-of-range matrix on the three-matrix instance.
    do_write(0, 3, 0, fill(8'h99));
    sel_mat = 2'd3; sel_line = 6'd3; sel_col = 3'd0;
    rd = 1'b1;
    tick();
    chk("err_pulse", e_err, 1);
    chk("err_busy", e_busy, 0);
    chk("err_main_clean", err, 0);
    rd = 1'b0;
    ne = 0; nv = 0; nd = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (e_err) ne++;
      if (e_vld) nv++;
      if (e_done) nd++;
    end
    chk("err_single", ne, 0);
    chk("err_no_vld", nv, 0);
    chk("err_no_done", nd, 0);
    do_read(0, 3, 0, t);
    chk_tile("err_main_mat0", t, fill(8'h99));
    chk_tile("err_inst_mat0", e_omat, fill(8'h99));

    // Reset during a write: rows 0..6 land at edges 1..7, the rest keep old contents.
    a_t = rand_tile();
    b_t = rand_tile();
    do_write(2, 4, 1, a_t);
    sel_mat = 2'd2; sel_line = 6'd4; sel_col = 3'd1; imat = b_t;
    wr = 1'b1;
    tick();
    wr = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_vld", vld, 0);
    chk("rstmid_done", done, 0);
    chk_tile("rstmid_mat", omat, '0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) nd++;
    end
    chk("rstmid_no_done", nd, 0);
    rst = 1'b0;
    tick();
    exp_t = a_t;
    for (int r = 0; r < 7; r++) exp_t[r*ROW_W +: ROW_W] = b_t[r*ROW_W +: ROW_W];
    model_put(key(2, 4, 1), exp_t);
    do_read(2, 4, 1, t);
    chk_tile("rstmid_partial", t, exp_t);

`ifdef BRAM_TILE_TRANSPOSE_EN
    for (int r = 0; r < TILE_DIM; r++)
      for (int cc = 0; cc < TILE_DIM; cc++) begin
        a_t[(r*TILE_DIM+cc)*DATA_W +: DATA_W] = 8'(r);
        exp_t[(r*TILE_DIM+cc)*DATA_W +: DATA_W] = 8'(cc);
      end
    do_write(1, 5, 2, a_t);
    tr = 1'b1;
    do_read(1, 5, 2, t);
    tr = 1'b0;
    chk_tile("transpose_tile", t, exp_t);
`endif

    // Randomized mix of writes and reads against the tile-level reference store.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 99) < 50) begin
        do_write($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), rand_tile());
      end else begin
        k = keys[$urandom_range(0, keys.size() - 1)];
        m = k >> 16; l = (k >> 8) & 255; c = k & 255;
`ifdef BRAM_TILE_TRANSPOSE_EN
        tr = 1'($urandom_range(0, 1));
`else
        tr = 1'b0;
`endif
        do_read(m, l, c, t);
        exp_t = tr ? transpose_t(model[k]) : model[k];
        tr = 1'b0;
        chk_tile("random_read", t, exp_t);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
